// File: rtl/ntt_pkg.sv
// Shared constants and modular helpers for the Kyber NTT datapath.
// Barrett constants assume products below 2^BARRETT_K, i.e. Q^2 < 2^24.
package ntt_pkg;

  localparam int DATA_WIDTH_DEFAULT = 12;
  localparam int Q                  = 3329;
  localparam int BARRETT_K          = 24;
  localparam int BARRETT_M          = (2 ** BARRETT_K) / Q;

  typedef logic [DATA_WIDTH_DEFAULT-1:0] coeff_t;
  typedef logic [DATA_WIDTH_DEFAULT:0]   coeff_ext_t;

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } bf_mode_t;

  localparam coeff_ext_t Q_EXT = coeff_ext_t'(Q);

  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
    coeff_ext_t sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= Q_EXT) sum = sum - Q_EXT;
    return coeff_t'(sum);
  endfunction

  // A borrow out of the extended width marks a negative difference.
  function automatic coeff_t mod_sub(input coeff_t a, input coeff_t b);
    coeff_ext_t diff;
    diff = {1'b0, a} - {1'b0, b};
    if (diff[DATA_WIDTH_DEFAULT]) diff = diff + Q_EXT;
    return coeff_t'(diff);
  endfunction

endpackage

// File: rtl/ntt_butterfly_if.sv
// Butterfly request/response bus between the NTT controller (master)
// and the butterfly unit (slave).
interface ntt_butterfly_if #(
  parameter int DATA_WIDTH = ntt_pkg::DATA_WIDTH_DEFAULT
) ();

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] butterfly_in1;
  logic [DATA_WIDTH-1:0] butterfly_in2;
  logic [DATA_WIDTH-1:0] butterfly_twiddle;
  logic                  butterfly_inverse;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] butterfly_u;
  logic [DATA_WIDTH-1:0] butterfly_v;
  logic                  idle;

  modport master (
    output valid_in, butterfly_in1, butterfly_in2, butterfly_twiddle, butterfly_inverse,
    input  valid_out, butterfly_u, butterfly_v, idle
  );

  modport slave (
    input  valid_in, butterfly_in1, butterfly_in2, butterfly_twiddle, butterfly_inverse,
    output valid_out, butterfly_u, butterfly_v, idle
  );

endinterface

// File: rtl/ntt_butterfly_barrett_reduce.sv
// Two-stage Barrett reduction of a product below Q^2 into [0,Q): the first
// stage registers p and floor(p*M/2^K), the second forms the remainder.
module barrett_reduce
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [2*DATA_WIDTH-1:0] product,
  output logic                    result_valid,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int MW = $clog2(BARRETT_M + 1);
  localparam int XW = PW + MW;
  localparam logic [DATA_WIDTH:0] Q_W = (DATA_WIDTH + 1)'(Q);

  logic [XW-1:0]         scaled;
  logic [DATA_WIDTH-1:0] quot_next;
  logic [PW-1:0]         p_q;
  logic [DATA_WIDTH-1:0] quot_q;
  logic                  valid_q;
  logic [PW-1:0]         quot_times_q;
  logic [DATA_WIDTH:0]   rem;

  // The Barrett product stays alone in this stage so it maps onto one DSP.
  assign scaled    = XW'(product) * XW'(BARRETT_M);
  assign quot_next = DATA_WIDTH'(scaled >> BARRETT_K);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      p_q     <= '0;
      quot_q  <= '0;
    end else begin
      valid_q <= valid;
      if (valid) begin
        p_q    <= product;
        quot_q <= quot_next;
      end
    end
  end

  // The quotient underestimates by at most one, so p - t*Q lies in [0,2Q).
  assign quot_times_q = PW'(quot_q) * PW'(Q);
  assign rem          = (DATA_WIDTH + 1)'(p_q - quot_times_q);

  assign result       = (rem >= Q_W) ? DATA_WIDTH'(rem - Q_W) : rem[DATA_WIDTH-1:0];
  assign result_valid = valid_q;

endmodule

// File: rtl/ntt_butterfly.sv
// Pipelined CT (NTT) / GS (INTT) butterfly modulo Q with a fixed latency,
// one transaction per cycle and no backpressure.
module ntt_butterfly
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int LATENCY    = 3
) (
  input  logic            clk,
  input  logic            rst,
  ntt_butterfly_if.slave  bus
);

  localparam int PW   = 2 * DATA_WIDTH;
  localparam int TAIL = LATENCY - 3;

  // Stage 1: modular add/sub on the raw operands and the single multiplier.
  bf_mode_t              mode_in;
  logic [DATA_WIDTH-1:0] sum_ab;
  logic [DATA_WIDTH-1:0] diff_ab;
  logic [DATA_WIDTH-1:0] mul_x;
  logic [DATA_WIDTH-1:0] carry_next;
  logic [PW-1:0]         prod_next;

  assign mode_in    = bf_mode_t'(bus.butterfly_inverse);
  assign sum_ab     = mod_add(bus.butterfly_in1, bus.butterfly_in2);
  assign diff_ab    = mod_sub(bus.butterfly_in1, bus.butterfly_in2);
  assign mul_x      = (mode_in == MODE_INTT) ? diff_ab : bus.butterfly_in2;
  assign carry_next = (mode_in == MODE_INTT) ? sum_ab : bus.butterfly_in1;
  assign prod_next  = PW'(mul_x) * PW'(bus.butterfly_twiddle);

  logic                  valid1;
  logic [PW-1:0]         prod1;
  logic [DATA_WIDTH-1:0] carry1;
  bf_mode_t              mode1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1 <= 1'b0;
      prod1  <= '0;
      carry1 <= '0;
      mode1  <= MODE_NTT;
    end else begin
      valid1 <= bus.valid_in;
      if (bus.valid_in) begin
        prod1  <= prod_next;
        carry1 <= carry_next;
        mode1  <= mode_in;
      end
    end
  end

  // Stages 2-3: Barrett reduction; a or s and the mode ride alongside it.
  logic                  valid2;
  logic [DATA_WIDTH-1:0] r;
  logic [DATA_WIDTH-1:0] carry2;
  bf_mode_t              mode2;

  barrett_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_barrett (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid1),
    .product      (prod1),
    .result_valid (valid2),
    .result       (r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry2 <= '0;
      mode2  <= MODE_NTT;
    end else if (valid1) begin
      carry2 <= carry1;
      mode2  <= mode1;
    end
  end

  logic [DATA_WIDTH-1:0] u_next;
  logic [DATA_WIDTH-1:0] v_next;

  // NOTE: every output gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    u_next = carry2;
    v_next = r;
    if (mode2 == MODE_NTT) begin
      u_next = mod_add(carry2, r);
      v_next = mod_sub(carry2, r);
    end
  end

  // Result stage (index 0) followed by TAIL plain delay stages; data only
  // loads with a valid so outputs hold their last result across bubbles.
  logic                  valid_pipe [0:TAIL];
  logic [DATA_WIDTH-1:0] u_pipe     [0:TAIL];
  logic [DATA_WIDTH-1:0] v_pipe     [0:TAIL];
  logic [TAIL:0]         valid_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_pipe[0] <= 1'b0;
      u_pipe[0]     <= '0;
      v_pipe[0]     <= '0;
    end else begin
      valid_pipe[0] <= valid2;
      if (valid2) begin
        u_pipe[0] <= u_next;
        v_pipe[0] <= v_next;
      end
    end
  end

  for (genvar s = 1; s <= TAIL; s++) begin : g_tail
    // NOTE: these delay registers are reset like any other flop because
    // reset must discard in-flight results and zero the outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_pipe[s] <= 1'b0;
        u_pipe[s]     <= '0;
        v_pipe[s]     <= '0;
      end else begin
        valid_pipe[s] <= valid_pipe[s-1];
        if (valid_pipe[s-1]) begin
          u_pipe[s] <= u_pipe[s-1];
          v_pipe[s] <= v_pipe[s-1];
        end
      end
    end
  end

  for (genvar s = 0; s <= TAIL; s++) begin : g_valid_bits
    assign valid_bits[s] = valid_pipe[s];
  end

  assign bus.valid_out   = valid_pipe[TAIL];
  assign bus.butterfly_u = u_pipe[TAIL];
  assign bus.butterfly_v = v_pipe[TAIL];
  assign bus.idle        = ~(valid1 | valid2 | (|valid_bits));

endmodule

// File: tb/tb_ntt_butterfly.sv
// Scoreboard bench for ntt_butterfly: two instances (LATENCY 3 and 5) share
// one stimulus stream, each checked against a plain-arithmetic reference.
module tb_ntt_butterfly;

  localparam int Q  = 3329;
  localparam int DW = 12;

  typedef struct {
    int unsigned u;
    int unsigned v;
    int          issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t        sbq [2][$];
  int unsigned last_u [2];
  int unsigned last_v [2];

  ntt_butterfly_if #(.DATA_WIDTH(DW)) bus3 ();
  ntt_butterfly_if #(.DATA_WIDTH(DW)) bus5 ();

  ntt_butterfly #(.DATA_WIDTH(DW), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  ntt_butterfly #(.DATA_WIDTH(DW), .LATENCY(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL time limit: simulation did not complete, got running expected finished");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the butterfly definitions.
  function automatic void model(input int a, input int b, input int w, input bit inv,
                                output int u, output int v);
    int wb;
    if (!inv) begin
      wb = (w * b) % Q;
      u  = (a + wb) % Q;
      v  = (a - wb + Q) % Q;
    end else begin
      u = (a + b) % Q;
      v = (((a - b + Q) % Q) * w) % Q;
    end
  endfunction

  task automatic set_inputs(input bit vin, input int a, input int b, input int w, input bit inv);
    bus3.valid_in          = vin;
    bus3.butterfly_in1     = DW'(a);
    bus3.butterfly_in2     = DW'(b);
    bus3.butterfly_twiddle = DW'(w);
    bus3.butterfly_inverse = inv;
    bus5.valid_in          = vin;
    bus5.butterfly_in1     = DW'(a);
    bus5.butterfly_in2     = DW'(b);
    bus5.butterfly_twiddle = DW'(w);
    bus5.butterfly_inverse = inv;
  endtask

  // Inputs change 1 time unit after an edge and are sampled on the next one.
  task automatic send_exp(input int a, input int b, input int w, input bit inv,
                          input int eu, input int ev, input bit drop_rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (drop_rst) rst = 1'b0;
    set_inputs(1'b1, a, b, w, inv);
    e.u     = eu;
    e.v     = ev;
    e.issue = cyc + 1;
    sbq[0].push_back(e);
    sbq[1].push_back(e);
  endtask

  task automatic send(input int a, input int b, input int w, input bit inv);
    int eu, ev;
    model(a, b, w, inv, eu, ev);
    send_exp(a, b, w, inv, eu, ev, 1'b0);
  endtask

  task automatic send_random();
    send($urandom_range(Q - 1, 0), $urandom_range(Q - 1, 0),
         $urandom_range(Q - 1, 0), 1'($urandom_range(1, 0)));
  endtask

  task automatic bubbles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      set_inputs(1'b0, $urandom_range(4095, 0), $urandom_range(4095, 0),
                 $urandom_range(4095, 0), 1'($urandom_range(1, 0)));
    end
  endtask

  task automatic monitor(input int d, input int lat, input logic vout,
                         input logic [DW-1:0] u, input logic [DW-1:0] v, input logic idle);
    string tag;
    exp_t  e;
    bit    exp_idle;
    tag = (d == 0) ? "lat3" : "lat5";
    if (rst) begin
      check({tag, " reset valid_out"}, vout, 0);
      check({tag, " reset u"}, u, 0);
      check({tag, " reset v"}, v, 0);
      check({tag, " reset idle"}, idle, 1);
      sbq[d].delete();
      last_u[d] = 0;
      last_v[d] = 0;
    end else begin
      exp_idle = !(sbq[d].size() > 0 && sbq[d][0].issue <= cyc);
      check({tag, " idle"}, idle, exp_idle);
      if (vout) begin
        if (sbq[d].size() == 0) begin
          check({tag, " unexpected valid_out"}, 1, 0);
        end else begin
          e = sbq[d].pop_front();
          check({tag, " u"}, u, e.u);
          check({tag, " v"}, v, e.v);
          check({tag, " latency"}, cyc - e.issue + 1, lat);
          last_u[d] = e.u;
          last_v[d] = e.v;
        end
      end else begin
        check({tag, " hold u"}, u, last_u[d]);
        check({tag, " hold v"}, v, last_v[d]);
        if (sbq[d].size() > 0 && cyc >= sbq[d][0].issue + lat - 1) begin
          check({tag, " valid_out missing"}, 0, 1);
          void'(sbq[d].pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitor(0, 3, bus3.valid_out, bus3.butterfly_u, bus3.butterfly_v, bus3.idle);
    monitor(1, 5, bus5.valid_out, bus5.butterfly_u, bus5.butterfly_v, bus5.idle);
  end

  initial begin
    set_inputs(1'b0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bubbles(2);

    // Directed vectors with hand-derived results.
    send_exp(5, 7, 17, 1'b0, 124, 3215, 1'b0);
    bubbles(8);
    send_exp(5, 7, 17, 1'b1, 12, 3295, 1'b0);
    bubbles(8);
    send_exp(3328, 3328, 3328, 1'b0, 0, 3327, 1'b0);
    bubbles(8);
    send_exp(3328, 3328, 3328, 1'b1, 3327, 0, 1'b0);
    bubbles(8);

    // Back-to-back random traffic with mixed modes.
    for (int i = 0; i < 256; i++) send_random();
    bubbles(10);

    // Reset one cycle after two consecutive transactions discards them.
    send_random();
    send_random();
    @(posedge clk);
    #1;
    set_inputs(1'b0, 0, 0, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    send_exp(5, 7, 17, 1'b0, 124, 3215, 1'b1);
    bubbles(8);

    // Isolated transactions separated by two-cycle bubbles.
    for (int i = 0; i < 20; i++) begin
      send_random();
      bubbles(2);
    end

    for (int i = 0; i < 50 && (sbq[0].size() != 0 || sbq[1].size() != 0); i++)
      @(posedge clk);
    @(negedge clk);
    check("drain lat3", sbq[0].size(), 0);
    check("drain lat5", sbq[1].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
